reg_file_wb: RTL and testbench

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/cpu_pkg.sv | 9 +
 rtl/wb_queue.sv | 66 ++++++
 rtl/reg_file_wb.sv | 70 +++++++
 tb/tb_reg_file_wb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths, register-address type and ring-index helper.
package cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  function automatic int wrap_idx(input int k, input int d);
    return (k >= d) ? k - d : k;
  endfunction
endpackage

// File: rtl/wb_queue.sv
// wb_queue: write-back FIFO with valid/ready push, pop, head and age-ordered entry view for bypass.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int AW    = DEF_ADDR_W,
  parameter int DW    = DEF_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [AW-1:0]    push_addr_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  output logic             pop_fire_o,
  output logic [AW-1:0]    head_addr_o,
  output logic [DW-1:0]    head_data_o,
  output logic             nonempty_o,
  output logic [DEPTH-1:0] ent_valid_o,
  output logic [AW-1:0]    ent_addr_o [DEPTH],
  output logic [DW-1:0]    ent_data_o [DEPTH]
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic push, pop;
  assign push_ready_o = cnt_q < CW'(DEPTH);
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_i & (cnt_q != '0);
  assign pop_fire_o   = pop;
  assign nonempty_o   = cnt_q != '0;
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  // Entry view is ordered oldest (index 0) to youngest so the reader can let later matches win.
  always_comb begin
    wr_ptr_d = push ? PW'(wrap_idx(int'(wr_ptr_q) + 1, DEPTH)) : wr_ptr_q;
    rd_ptr_d = pop ? PW'(wrap_idx(int'(rd_ptr_q) + 1, DEPTH)) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = CW'(i) < cnt_q;
      ent_addr_o[i]  = addr_q[PW'(wrap_idx(int'(rd_ptr_q) + i, DEPTH))];
      ent_data_o[i]  = data_q[PW'(wrap_idx(int'(rd_ptr_q) + i, DEPTH))];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: register file fed by a write-back queue, with youngest-entry read bypass.
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wr_hold,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_pending
);
  localparam int NREG = 2 ** ADDR_W;
  logic                 init_q;
  logic                 drain;
  logic [ADDR_W-1:0]    head_addr;
  logic [DATA_W-1:0]    head_data;
  logic [NREG-1:0]      we;
  logic [Q_DEPTH-1:0]   ent_valid;
  logic [ADDR_W-1:0]    ent_addr [Q_DEPTH];
  logic [DATA_W-1:0]    ent_data [Q_DEPTH];
  logic [DATA_W-1:0]    regs_q [NREG];
  // init_q blocks acceptance on the edge that coincides with reset release.
  wb_queue #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(Q_DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (wb_valid & init_q),
    .push_ready_o (wb_ready),
    .push_addr_i  (wb_addr),
    .push_data_i  (wb_data),
    .pop_i        (~wr_hold),
    .pop_fire_o   (drain),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .nonempty_o   (wb_pending),
    .ent_valid_o  (ent_valid),
    .ent_addr_o   (ent_addr),
    .ent_data_o   (ent_data)
  );
  assign we = drain ? ((NREG'(1) << head_addr) & ~NREG'(1)) : '0;
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs_q[a];
    for (int i = 0; i < Q_DEPTH; i++)
      if (ent_valid[i] && ent_addr[i] == a) v = ent_data[i];
    return (a == '0) ? '0 : v;
  endfunction
  always_comb begin
    rd_data_a = rd(rd_addr_a);
    rd_data_b = rd(rd_addr_b);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      init_q <= 1'b1;
      for (int r = 0; r < NREG; r++) if (we[r]) regs_q[r] <= head_data;
    end
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed scenario tests for reg_file_wb with hand-computed expectations.
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wr_hold = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        wb_pending;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [32];

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .Q_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wr_hold    (wr_hold),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wb_pending (wb_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] b_addr(input int k);
    return 5'((k % 31) + 1);
  endfunction

  function automatic logic [31:0] b_data(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int r = 0; r < 32; r++) begin
      rd_addr_a = 5'(r);
      rd_addr_b = 5'(31 - r);
      #1;
      n_cmp++;
      if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL reset_rd_a r%0d: got %h want 00000000", r, rd_data_a); end
      n_cmp++;
      if (rd_data_b !== 32'h0) begin n_bad++; $display("FAIL reset_rd_b r%0d: got %h want 00000000", 31 - r, rd_data_b); end
    end
    n_cmp++;
    if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", wb_ready); end
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", wb_pending); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    rd_addr_a = 5'd5;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL bypass_offered: got %h want 00000000", rd_data_a); end
    step();
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_queued: got %h want deadbeef", rd_data_a); end
    n_cmp++;
    if (wb_pending !== 1'b1) begin n_bad++; $display("FAIL bypass_pending: got %b want 1", wb_pending); end
    step();
    n_cmp++;
    if (rd_data_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_written: got %h want deadbeef", rd_data_a); end
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL bypass_drained: got %b want 0", wb_pending); end
  endtask

  task automatic test_hold();
    wr_hold = 1'b1;
    rd_addr_a = 5'd7; rd_addr_b = 5'd3;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    step();
    wb_data = 32'h22;
    step();
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL hold_full_ready: got %b want 0", wb_ready); end
    n_cmp++;
    if (rd_data_b !== 32'h22) begin n_bad++; $display("FAIL hold_youngest: got %h want 00000022", rd_data_b); end
    step();
    n_cmp++;
    if (wb_pending !== 1'b1) begin n_bad++; $display("FAIL hold_frozen: got %b want 1", wb_pending); end
    wr_hold = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    step();
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready_after_drain: got %b want 1", wb_ready); end
    n_cmp++;
    if (wb_pending !== 1'b1) begin n_bad++; $display("FAIL hold_one_left: got %b want 1", wb_pending); end
    n_cmp++;
    if (rd_data_b !== 32'h22) begin n_bad++; $display("FAIL hold_mid_r3: got %h want 00000022", rd_data_b); end
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL hold_full_reject: got %h want 00000000", rd_data_a); end
    step();
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL hold_empty: got %b want 0", wb_pending); end
    n_cmp++;
    if (rd_data_b !== 32'h22) begin n_bad++; $display("FAIL hold_order_r3: got %h want 00000022", rd_data_b); end
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL hold_r7_untouched: got %h want 00000000", rd_data_a); end
  endtask

  task automatic test_zero();
    rd_addr_a = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %b want 1", wb_ready); end
    step();
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if (wb_pending !== 1'b1) begin n_bad++; $display("FAIL zero_accepted: got %b want 1", wb_pending); end
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL zero_bypass: got %h want 00000000", rd_data_a); end
    step();
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL zero_drained: got %b want 0", wb_pending); end
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL zero_array: got %h want 00000000", rd_data_a); end
  endtask

  task automatic test_reset_mid();
    wr_hold = 1'b1;
    rd_addr_a = 5'd3; rd_addr_b = 5'd5;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    step();
    wb_data = 32'hBB;
    step();
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_full: got %b want 0", wb_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL rstmid_pending: got %b want 0", wb_pending); end
    n_cmp++;
    if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", wb_ready); end
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL rstmid_r3: got %h want 00000000", rd_data_a); end
    n_cmp++;
    if (rd_data_b !== 32'h0) begin n_bad++; $display("FAIL rstmid_r5: got %h want 00000000", rd_data_b); end
    step();
    step();
    rst_n = 1'b1;
    wr_hold = 1'b0;
    step();
    step();
    n_cmp++;
    if (rd_data_a !== 32'h0) begin n_bad++; $display("FAIL rstmid_no_write: got %h want 00000000", rd_data_a); end
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL rstmid_still_empty: got %b want 0", wb_pending); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    wr_hold = 1'b0;
    wb_valid = 1'b1; wb_addr = b_addr(0); wb_data = b_data(0);
    for (int k = 0; k < 64; k++) begin
      #1;
      n_cmp++;
      if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready k=%0d: got %b want 1", k, wb_ready); end
      step();
      model[b_addr(k)] = b_data(k);
      rd_addr_a = b_addr(k);
      rd_addr_b = (k > 0) ? b_addr(k - 1) : 5'd0;
      #1;
      n_cmp++;
      if (rd_data_a !== b_data(k)) begin n_bad++; $display("FAIL b2b_bypass k=%0d: got %h want %h", k, rd_data_a, b_data(k)); end
      if (k > 0) begin
        n_cmp++;
        if (rd_data_b !== b_data(k - 1)) begin n_bad++; $display("FAIL b2b_written k=%0d: got %h want %h", k, rd_data_b, b_data(k - 1)); end
      end
      n_cmp++;
      if (wb_pending !== 1'b1) begin n_bad++; $display("FAIL b2b_pending k=%0d: got %b want 1", k, wb_pending); end
      if (k < 63) begin
        wb_addr = b_addr(k + 1);
        wb_data = b_data(k + 1);
      end else begin
        wb_valid = 1'b0;
      end
    end
    step();
    n_cmp++;
    if (wb_pending !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", wb_pending); end
    for (int r = 1; r < 32; r++) begin
      rd_addr_a = 5'(r);
      #1;
      n_cmp++;
      if (rd_data_a !== model[r]) begin n_bad++; $display("FAIL b2b_final r%0d: got %h want %h", r, rd_data_a, model[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_hold();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
